// File: rtl/lif_neuron_array.sv
// lif_neuron_array: neuron array with saturating integrate, leak, sign-compare or LIF fire, spike counting and argmax classification
module lif_neuron_array #(
  parameter int NUM_NEURONS = 16,
  parameter int STIM_W      = 16,
  parameter int POT_W       = 20,
  parameter int CNT_W       = 8,
  parameter int REFRAC_W    = 4,
  parameter int IDX_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic signed [POT_W-1:0]    threshold,
  input  logic [3:0]                 leak_shift,
  input  logic [REFRAC_W-1:0]        refrac_len,
  input  logic                       stim_valid,
  input  logic signed [STIM_W-1:0]   stimuli,
  input  logic [NUM_NEURONS-1:0]     connection,
  input  logic                       leak_tick,
  input  logic                       picture_done,
  output logic [NUM_NEURONS-1:0]     spike_o,
  output logic [IDX_W-1:0]           class_o,
  output logic                       class_valid
);
  logic signed [POT_W-1:0] pot    [NUM_NEURONS];
  logic signed [POT_W-1:0] pot_n  [NUM_NEURONS];
  logic signed [POT_W-1:0] p_new  [NUM_NEURONS];
  logic [CNT_W-1:0]        cnt    [NUM_NEURONS];
  logic [CNT_W-1:0]        cnt_n  [NUM_NEURONS];
  logic [REFRAC_W-1:0]     refr   [NUM_NEURONS];
  logic [REFRAC_W-1:0]     refr_n [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]  blk, integ, ge, fire, rise, spk_n;
  logic [IDX_W-1:0]        best_idx;
  logic [CNT_W-1:0]        best_cnt;

  // One extra bit catches overflow; the clamp pins to the nearest rail
  function automatic logic signed [POT_W-1:0] sat_add(input logic signed [POT_W-1:0] p,
                                                      input logic signed [STIM_W-1:0] s);
    logic [POT_W:0] sum;
    sum = {p[POT_W-1], p} + {{(POT_W+1-STIM_W){s[STIM_W-1]}}, s};
    return (sum[POT_W] != sum[POT_W-1]) ? {sum[POT_W], {(POT_W-1){~sum[POT_W]}}} : sum[POT_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      blk[i]    = mode && refr[i] != '0;
      integ[i]  = stim_valid && connection[i] && !blk[i];
      p_new[i]  = integ[i] ? sat_add(pot[i], stimuli)
                : (!stim_valid && leak_tick && !blk[i] && leak_shift != 4'd0) ? pot[i] - (pot[i] >>> leak_shift)
                : pot[i];
      ge[i]     = p_new[i] >= threshold;
      fire[i]   = mode && integ[i] && ge[i];
      rise[i]   = mode ? fire[i] : ge[i] && !spike_o[i];
      spk_n[i]  = !picture_done && (mode ? fire[i] : ge[i]);
      pot_n[i]  = (picture_done || fire[i]) ? '0 : p_new[i];
      cnt_n[i]  = picture_done ? '0 : (rise[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
      refr_n[i] = picture_done ? '0 : fire[i] ? refrac_len : (refr[i] != '0) ? refr[i] - 1'b1 : refr[i];
    end
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    best_idx = '0;
    best_cnt = cnt[0];
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (cnt[i] > best_cnt) begin
        best_cnt = cnt[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pot         <= '{default: '0};
      cnt         <= '{default: '0};
      refr        <= '{default: '0};
      spike_o     <= '0;
      class_o     <= '0;
      class_valid <= 1'b0;
    end else begin
      pot         <= pot_n;
      cnt         <= cnt_n;
      refr        <= refr_n;
      spike_o     <= spk_n;
      class_valid <= picture_done;
      class_o     <= picture_done ? best_idx : class_o;
    end
  end
endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Parametrised successor to the 16-neuron integrate block behind the synapse matrix. Each neuron accumulates signed stimuli with a saturating add into a wider potential and compares it against a programmable threshold. It supports two modes: legacy sign-compare, and leaky integrate-and-fire with refractory period and per-neuron spike counting. At picture end it reports the winning neuron index to the classification logic.

Parameters:
- NUM_NEURONS, 16, neuron count (one per macro column group); 2..64.
- STIM_W, 16, signed stimulus width.
- POT_W, 20, signed potential width; must be >= STIM_W.
- CNT_W, 8, per-neuron saturating spike-counter width.
- REFRAC_W, 4, refractory counter width.
- IDX_W, 4, class index width; equals clog2(NUM_NEURONS).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- mode, input, 1, 0 = legacy sign-compare, 1 = LIF fire-and-reset.
- threshold, input, POT_W, signed firing threshold; quasi-static, changed only between pictures.
- leak_shift, input, 4, leak amount = potential >>> leak_shift; 0 disables leak.
- refrac_len, input, REFRAC_W, cycles a neuron ignores stimuli after firing (mode 1).
- stim_valid, input, 1, stimulus ack from synapse matrix.
- stimuli, input, STIM_W, signed stimulus, broadcast to all neurons.
- connection, input, NUM_NEURONS, per-neuron enable for this stimulus.
- leak_tick, input, 1, one-cycle timestep strobe that applies leak.
- picture_done, input, 1, one-cycle end-of-picture strobe.
- spike_o, output, NUM_NEURONS, mode 0: level; mode 1: one-cycle pulse per fire.
- class_o, output, IDX_W, winning neuron index, held until next class_valid.
- class_valid, output, 1, one-cycle pulse.

Behaviour:
- Reset (rst=0, async): all potentials, spike counters, refractory counters, spike_o, class_o and class_valid go to 0.
- Priority per cycle: picture_done > stim_valid > leak_tick. Lower-priority events that cycle are dropped.
- Integrate: on stim_valid, each neuron with connection[i]=1 that is not refractory computes p' = p + sign-extend(stimuli), saturated to [-2^(POT_W-1), 2^(POT_W-1)-1]. No wrap-around.
- Leak: on leak_tick, each non-refractory neuron computes p' = p - (p >>> leak_shift), arithmetic shift, decaying toward 0. It has no effect when leak_shift=0. A negative p moves toward 0 the same way.
- Mode 0: spike_o[i] = registered (p_i >= threshold), updated every cycle. There is no reset-on-fire and no refractory. The counter increments on each 0->1 transition of spike_o[i]. With threshold=0 this matches the legacy sign-bit behaviour, one cycle later.
- Mode 1: if p' >= threshold after an integrate:
  - p is set to 0.
  - spike_o[i] pulses high the next cycle.
  - The refractory counter loads refrac_len.
  - The spike counter increments, saturating at 2^CNT_W-1.
- Refractory counter decrements once per clk while nonzero. While nonzero, stim_valid and leak_tick are ignored for that neuron. refrac_len=0 means no refractory.
- picture_done, cycle T:
  - Registers the argmax of the spike counters as seen at T (before clearing).
  - Ties go to the lowest index. All-zero counts give class_o=0.
  - class_o updates and class_valid pulses in cycle T+1.
  - In the same edge, potentials, counters and refractory counters clear to 0.
  - spike_o is 0 in T+1.
- mode must change only between pictures. A change mid-picture gives undefined spike counts but no lock-up.
- Reset mid-picture: everything clears, class_valid is not emitted, and the next picture starts clean.
- Latency: stimulus at edge T gives potential at T+1 and spike_o at T+1 (registered compare on the new value).

Test Plan:
- Mode 0, threshold=0: neuron 3 gets stimuli=-5 then +8 → spike_o[3]=0 after the first stimulus, 1 after the second; p=3.
- Saturation, POT_W=20: 40 stimuli of +32767 to neuron 0 → p pins at 524287 and never goes negative.
- Mode 1, threshold=100, refrac_len=3: stimuli +60 ×3 to neuron 2 → pulse after the 2nd stimulus and p=0. The 3rd stimulus, arriving within 3 cycles, is ignored. A 4th stimulus after refractory gives p=60.
- Leak: p=64, leak_shift=2, 3 leak_ticks → p=48, 36, 27.
- Classification: counts neuron1=5, neuron4=7, neuron9=7, then picture_done → class_o=4 and class_valid pulses exactly 1 cycle later. All state is 0 after.
- Collision and reset: picture_done coincident with stim_valid → stimulus dropped and potentials 0. Assert rst low mid-picture, asynchronously between edges → outputs 0 immediately, no class_valid.
